// File: rtl/keccak_f200_sponge.sv
// Sequential Keccak-f[200] sponge: absorbs RATE-bit blocks into the rate, runs one
// round_200 per clock for 18 rounds, then presents the rate as output.

module round_200 (
  input  logic [199:0] i_state,
  input  logic [7:0]   i_rc,
  output logic [199:0] o_state
);
  // Rho offsets reduced mod 8, indexed by lane x+5*y
  localparam int RHO [25] = '{0, 1, 6, 4, 3,
                              4, 4, 6, 7, 4,
                              3, 2, 3, 1, 7,
                              1, 5, 7, 5, 0,
                              2, 2, 5, 0, 6};

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    rol8 = (v << n) | (v >> (8 - n));
  endfunction

  // Lane i lives in i_state[199-8*i -: 8]; lane bit z is bit z of that byte.
  function automatic logic [199:0] round_fn(input logic [199:0] s, input logic [7:0] rc);
    logic [7:0] a [25];
    logic [7:0] b [25];
    logic [7:0] c [5];
    logic [7:0] d [5];
    for (int i = 0; i < 25; i++) a[i] = s[199-8*i -: 8];
    for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
    for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rol8(c[(x+1)%5], 1);
    for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[y + 5*((2*x + 3*y) % 5)] = rol8(a[x + 5*y], RHO[x + 5*y]);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        a[x + 5*y] = b[x + 5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
    a[0] = a[0] ^ rc;
    round_fn = '0;
    for (int i = 0; i < 25; i++) round_fn[199-8*i -: 8] = a[i];
  endfunction

  assign o_state = round_fn(i_state, i_rc);
endmodule

module keccak_f200_sponge #(
  parameter int RATE    = 40,
  parameter int NROUNDS = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_absorb,
  input  logic [RATE-1:0] cmd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RATE-1:0] out_data,
  output logic            busy,
  output logic [1:0]      dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the source holds valid and payload stable until then, and ready never
  // depends on valid (cmd_ready only in IDLE, out_ready consumed only in OUT).
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PERM = 2'd1, ST_OUT = 2'd2} fsm_t;

  fsm_t         r_fsm, w_fsm_nxt;
  logic [199:0] r_state, w_state_nxt, w_round_out;
  logic [4:0]   r_rcnt, w_rcnt_nxt;
  logic [7:0]   w_rc;

  function automatic logic [7:0] rc_lut(input logic [4:0] n);
    case (n)
      5'd0:    rc_lut = 8'h01;
      5'd1:    rc_lut = 8'h82;
      5'd2:    rc_lut = 8'h8A;
      5'd3:    rc_lut = 8'h00;
      5'd4:    rc_lut = 8'h8B;
      5'd5:    rc_lut = 8'h01;
      5'd6:    rc_lut = 8'h81;
      5'd7:    rc_lut = 8'h09;
      5'd8:    rc_lut = 8'h8A;
      5'd9:    rc_lut = 8'h88;
      5'd10:   rc_lut = 8'h09;
      5'd11:   rc_lut = 8'h0A;
      5'd12:   rc_lut = 8'h8B;
      5'd13:   rc_lut = 8'h8B;
      5'd14:   rc_lut = 8'h89;
      5'd15:   rc_lut = 8'h03;
      5'd16:   rc_lut = 8'h02;
      5'd17:   rc_lut = 8'h80;
      default: rc_lut = 8'h00;
    endcase
  endfunction

  assign w_rc = rc_lut(r_rcnt);

  round_200 u_round (
    .i_state (r_state),
    .i_rc    (w_rc),
    .o_state (w_round_out)
  );

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    case (r_fsm)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_absorb) w_state_nxt[199 -: RATE] = r_state[199 -: RATE] ^ cmd_data;
          w_rcnt_nxt = 5'd0;
          w_fsm_nxt  = ST_PERM;
        end
      end
      ST_PERM: begin
        w_state_nxt = w_round_out;
        if (r_rcnt == 5'(NROUNDS - 1)) begin
          w_rcnt_nxt = 5'd0;
          w_fsm_nxt  = ST_OUT;
        end else begin
          w_rcnt_nxt = r_rcnt + 5'd1;
        end
      end
      ST_OUT: begin
        if (out_ready) w_fsm_nxt = ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
    // Wipe wins over everything, including a command presented in the same cycle
    if (clear) begin
      w_state_nxt = '0;
      w_rcnt_nxt  = 5'd0;
      w_fsm_nxt   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_rcnt  <= 5'd0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  assign cmd_ready = (r_fsm == ST_IDLE);
  assign busy      = (r_fsm == ST_PERM);
  assign out_valid = (r_fsm == ST_OUT);
  assign out_data  = r_state[199 -: RATE];
  assign dbg_state = r_fsm;
endmodule

// File: tb/tb_keccak_f200_sponge.sv
// Bench for keccak_f200_sponge: directed scenarios plus random absorb/squeeze traffic,
// compared against a bit-level Keccak-f[200] model built from the permutation rules.

module tb_keccak_f200_sponge;
  localparam int RATE = 40;

  logic            clk = 1'b0;
  logic            rst_n, clear, cmd_valid, cmd_absorb, out_ready;
  logic [RATE-1:0] cmd_data;
  logic            cmd_ready, out_valid, busy;
  logic [RATE-1:0] out_data;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [199:0]    m_state;
  logic [RATE-1:0] exp_q[$];
  logic [RATE-1:0] last_exp;
  int              rho [5][5];

  keccak_f200_sponge #(.RATE(RATE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_absorb (cmd_absorb),
    .cmd_data   (cmd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit rc_bit(input int t);
    int r = 1;
    for (int i = 0; i < t % 255; i++) begin
      r = r << 1;
      if ((r & 'h100) != 0) r = r ^ 'h171;
    end
    return bit'(r & 1);
  endfunction

  function automatic void build_rho();
    int x = 1, y = 0, nx;
    rho[0][0] = 0;
    for (int t = 0; t < 24; t++) begin
      rho[x][y] = ((t + 1) * (t + 2) / 2) % 8;
      nx = y;
      y  = (2 * x + 3 * y) % 5;
      x  = nx;
    end
  endfunction

  function automatic logic [199:0] keccak_f(input logic [199:0] s);
    bit a [5][5][8];
    bit b [5][5][8];
    bit c [5][8];
    logic [199:0] r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < 8; z++) a[x][y][z] = s[192 - 8*(x + 5*y) + z];
    for (int rnd = 0; rnd < 18; rnd++) begin
      for (int x = 0; x < 5; x++)
        for (int z = 0; z < 8; z++)
          c[x][z] = a[x][0][z] ^ a[x][1][z] ^ a[x][2][z] ^ a[x][3][z] ^ a[x][4][z];
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          for (int z = 0; z < 8; z++)
            a[x][y][z] ^= c[(x+4)%5][z] ^ c[(x+1)%5][(z+7)%8];
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          for (int z = 0; z < 8; z++)
            b[y][(2*x + 3*y)%5][z] = a[x][y][(z + 8 - rho[x][y]) % 8];
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          for (int z = 0; z < 8; z++)
            a[x][y][z] = b[x][y][z] ^ (~b[(x+1)%5][y][z] & b[(x+2)%5][y][z]);
      for (int j = 0; j < 4; j++) a[0][0][(1 << j) - 1] ^= rc_bit(j + 7 * rnd);
    end
    r = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < 8; z++) r[192 - 8*(x + 5*y) + z] = a[x][y][z];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit absorb, input logic [RATE-1:0] data);
    int waited = 0;
    cmd_valid = 1'b1; cmd_absorb = absorb; cmd_data = data;
    while (!cmd_ready && waited < 100) begin step(); waited++; end
    if (!cmd_ready) check("cmd_ready_timeout", 1'b0, 1'b1);
    step();
    cmd_valid = 1'b0; cmd_absorb = $urandom_range(0, 1); cmd_data = {$urandom, $urandom};
    check("accepted", busy, 1'b1);
    if (absorb) m_state[199 -: RATE] ^= data;
    m_state = keccak_f(m_state);
    exp_q.push_back(m_state[199 -: RATE]);
  endtask

  task automatic wait_out(input string tag);
    int lat = 0, busy_n = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      out_ready = $urandom_range(0, 1);
      step();
      lat++;
    end
    out_ready = 1'b0;
    if (!out_valid) check({tag, "_out_timeout"}, 1'b0, 1'b1);
    check({tag, "_latency"}, lat, 18);
    check({tag, "_busy_cycles"}, busy_n, 18);
    check({tag, "_cmd_ready_in_out"}, cmd_ready, 1'b0);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b0, 1'b1);
    end else begin
      last_exp = exp_q.pop_front();
      check({tag, "_data"}, out_data, last_exp);
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ret_idle", cmd_ready, 1'b1);
    check("ov_fall", out_valid, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [RATE-1:0] r1, o2a, o2b, od, d;
    int bad, seen;
    build_rho();
    rst_n = 1'b0; clear = 1'b0; cmd_valid = 1'b0; cmd_absorb = 1'b0;
    cmd_data = '0; out_ready = 1'b0; m_state = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_state", dbg_state, 2'd0);

    // Squeeze of zero state
    issue(1'b0, '0);
    wait_out("s1");
    r1 = last_exp;
    take_out();

    // Absorb then squeeze: chaining
    issue(1'b1, 40'h0000000001);
    wait_out("s2a");
    o2a = out_data;
    take_out();
    issue(1'b0, '0);
    wait_out("s2b");
    o2b = out_data;
    take_out();
    check("chain_differs", (o2a != o2b), 1'b1);

    // Long stall in OUT, then handshake with a command already waiting
    issue(1'b1, {$urandom, $urandom});
    wait_out("s3");
    od = out_data; bad = 0;
    repeat (50) begin
      step();
      if (!out_valid || out_data !== od || cmd_ready) bad++;
    end
    check("stall_hold", bad, 0);
    cmd_valid = 1'b1; cmd_absorb = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hs_no_accept", busy, 1'b0);
    check("hs_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("accept_next", busy, 1'b1);
    m_state = keccak_f(m_state);
    exp_q.push_back(m_state[199 -: RATE]);
    wait_out("s3b");
    take_out();

    // Clear mid-permutation
    issue(1'b0, '0);
    repeat (9) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_out_valid", out_valid, 1'b0);
    check("clr_idle", cmd_ready, 1'b1);
    check("clr_state", out_data, '0);
    exp_q.delete(); m_state = '0; seen = 0;
    repeat (30) begin step(); if (out_valid) seen++; end
    check("clr_no_output", seen, 0);
    issue(1'b0, '0);
    wait_out("s4");
    check("s4_vs_s1", out_data, r1);
    take_out();

    // Async reset between edges mid-permutation
    issue(1'b1, {$urandom, $urandom});
    repeat (7) step();
    #3 rst_n = 1'b0;
    #1;
    check("arst_cmd_ready", cmd_ready, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, '0);
    exp_q.delete(); m_state = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    issue(1'b0, '0);
    wait_out("s5");
    check("s5_vs_s1", out_data, r1);
    take_out();

    // Random absorb/squeeze traffic
    for (int k = 0; k < 8; k++) begin
      issue(1'($urandom_range(0, 1)), {$urandom, $urandom});
      wait_out("rnd");
      repeat ($urandom_range(0, 3)) step();
      take_out();
      repeat ($urandom_range(0, 2)) step();
    end

    // Clear together with a command in IDLE
    d = {$urandom, $urandom} | 40'h1;
    cmd_valid = 1'b1; cmd_absorb = 1'b1; cmd_data = d; clear = 1'b1;
    step();
    clear = 1'b0;
    check("clrcmd_not_accepted", busy, 1'b0);
    check("clrcmd_state_zero", out_data, '0);
    check("clrcmd_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("clrcmd_accept_next", busy, 1'b1);
    m_state = keccak_f({d, 160'b0});
    exp_q.push_back(m_state[199 -: RATE]);
    wait_out("s6");
    take_out();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/keccak_f200_sponge.md
Name: keccak_f200_sponge

Overview:
Sequential Keccak-f[200] sponge core for the RNG. It holds the 200-bit state and absorbs RATE-bit blocks by XOR into the rate portion. It iterates a single instance of round_200 over 18 rounds, one round per clock, with an internal round-constant table. After each permutation it presents the rate portion as RNG output, so it is the direct driver and consumer of round_200.

Parameters:
RATE, 40, rate width in bits; legal values 8..192, multiple of 8; occupies state[199:200-RATE] (lane (0,0) upward).
NROUNDS, 18, rounds per permutation; fixed by Keccak-f[200] (12+2*3); not to be overridden.

Ports:
clk  in  1  system clock; one clock; reset is asynchronous and active-low.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous state wipe; highest priority after reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  core can accept a command (high only in IDLE).
cmd_absorb  in  1  1 = XOR cmd_data into the rate, then permute; 0 = permute only (squeeze).
cmd_data  in  RATE  block to absorb; ignored when cmd_absorb=0.
out_valid  out  1  out_data holds a post-permutation rate.
out_ready  in  1  consumer accepts out_data.
out_data  out  RATE  state[199:200-RATE] after the last permutation.
busy  out  1  high in PERM.

Behaviour:
- Reset (rst_n=0, async): state=0, round counter=0, fsm=IDLE, cmd_ready=1, out_valid=0, busy=0, out_data=0.
- FSM states are IDLE, PERM and OUT.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready (edge T):
  - if cmd_absorb=1, state[199:200-RATE] ^= cmd_data, else state is unchanged;
  - rcnt=0; go to PERM.
- PERM: each edge applies state <= round_200(state, RC[rcnt]) and rcnt++.
  - On the edge with rcnt==17, go to OUT and clear rcnt.
  - 18 round edges in total; out_valid rises after edge T+18.
  - cmd_ready=0 and busy=1 throughout.
- RC[0..17] (low byte of the standard constants): 01 82 8A 00 8B 01 81 09 8A 88 09 0A 8B 8B 89 03 02 80.
  - rcnt is 5 bits; values 18..31 are unreachable and decode to 00.
- OUT: out_valid=1; out_data is combinational from the state register and stable while waiting.
  - On out_ready, go to IDLE; out_valid falls on the next edge.
  - A command cannot be accepted in the same cycle as the OUT handshake; the earliest acceptance is the following cycle.
  - Back-to-back throughput is 20 cycles per block.
- The state persists across commands (sponge chaining). Only reset or clear zeroes it.
- clear=1 at any edge, in any state: state=0, rcnt=0, go to IDLE, out_valid=0. Any in-flight permutation or pending output is discarded. clear overrides a simultaneous cmd handshake; that command is not accepted.
- rst_n asserted mid-PERM: everything returns immediately to reset values. No partial-permutation state survives.
- cmd_valid held during PERM/OUT has no effect. The requester must keep cmd_valid, cmd_absorb and cmd_data stable until cmd_ready.
- out_ready asserted outside OUT is ignored.
- Padding is the caller's responsibility. The core never pads.

Test Plan:
- Reset, then cmd_absorb=0 on zero state: out_valid rises exactly 18 cycles after the accept edge. out_data equals the top 40 bits of Keccak-f[200](0) from the golden C model. busy is high for exactly 18 cycles.
- Absorb cmd_data=40'h0000000001, then a squeeze command: each output matches the model for chained permutations, proving the state persists. The second result differs from the first.
- Hold out_ready=0 for 50 cycles in OUT: out_valid stays 1, out_data is constant, cmd_ready stays 0. Pulse out_ready: IDLE next cycle, and a command is accepted one cycle later.
- Assert clear at round 9 of a permutation: out_valid is never raised. A fresh squeeze then reproduces the result of the first scenario exactly.
- Pull rst_n low asynchronously mid-PERM, between edges: outputs go to reset values immediately. After release, the first-scenario result is reproduced.
- Assert clear together with cmd_valid in IDLE: the command is not accepted and the state stays 0. Keep cmd_valid high: the command is accepted the next cycle.
